// File: rtl/countdown_timer.sv
// Remaining-time countdown in BCD m:ss. It loads a duration, subtracts `step`
// seconds on every prescaler tick while running, and flags expiry at 0:00.
module countdown_timer #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_m0,
  input  logic [3:0] load_s1,
  input  logic [3:0] load_s0,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] step,
  output logic [3:0] minutes0,
  output logic [3:0] seconds1,
  output logic [3:0] seconds0,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [11:0]   digits_n;
  logic          done_n, expired_n;
  logic [9:0]    cur_t, next_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [9:0] to_secs(input logic [3:0] m, input logic [3:0] s1,
                                         input logic [3:0] s0);
    return 10'(m) * 10'd60 + 10'(s1) * 10'd10 + 10'(s0);
  endfunction

  // Saturating subtract: any step at or beyond the remaining time lands on zero.
  function automatic logic [9:0] sat_sub(input logic [9:0] t, input logic [5:0] s);
    logic signed [10:0] d;
    d = $signed({1'b0, t}) - $signed({5'b0, s});
    return (d <= 0) ? 10'd0 : d[9:0];
  endfunction

  function automatic logic [11:0] to_bcd(input logic [9:0] t);
    logic [3:0] m, s1, s0;
    logic [5:0] r;
    m  = 4'(t / 10'd60);
    r  = 6'(t - 10'(m) * 10'd60);
    s1 = 4'(r / 6'd10);
    s0 = 4'(r - 6'(s1) * 6'd10);
    return {m, s1, s0};
  endfunction

  assign cur_t  = to_secs(minutes0, seconds1, seconds0);
  assign next_t = sat_sub(cur_t, step);

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    digits_n  = {minutes0, seconds1, seconds0};
    done_n    = 1'b0;
    expired_n = expired;
    if (load) begin
      state_n   = IDLE;
      presc_n   = '0;
      digits_n  = {clamp_digit(load_m0, 4'd9), clamp_digit(load_s1, 4'd5),
                   clamp_digit(load_s0, 4'd9)};
      expired_n = 1'b0;
    end else begin
      unique case (state)
        IDLE, PAUSED: begin
          if (!pause && start && cur_t != 10'd0) state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (presc == PRESC_LAST) begin
            presc_n  = '0;
            digits_n = to_bcd(next_t);
            if (next_t == 10'd0) begin
              state_n   = DONE;
              done_n    = 1'b1;
              expired_n = 1'b1;
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      minutes0 <= '0;
      seconds1 <= '0;
      seconds0 <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state                          <= state_n;
      presc                          <= presc_n;
      {minutes0, seconds1, seconds0} <= digits_n;
      running                        <= (state_n == RUN);
      done                           <= done_n;
      expired                        <= expired_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle second; expected digits are
// written as 12'hMSS and flags as {running, done, expired}.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [3:0] load_m0, load_s1, load_s0;
  logic [5:0] step;
  logic [3:0] minutes0, seconds1, seconds0;
  logic       running, done, expired;
  int vectors = 0;
  int miscompares = 0;

  countdown_timer #(.CLKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_m0(load_m0), .load_s1(load_s1),
    .load_s0(load_s0), .start(start), .pause(pause), .step(step),
    .minutes0(minutes0), .seconds1(seconds1), .seconds0(seconds0),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [11:0] d);
    {load_m0, load_s1, load_s0} = d;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(2);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h000) begin
      miscompares++; $display("FAIL reset_digits got %h want 000", {minutes0, seconds1, seconds0});
    end
    vectors++;
    if ({running, done, expired} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b want 000", {running, done, expired});
    end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_full_countdown();
    step = 6'd1;
    do_load(12'h100);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h100) begin
      miscompares++; $display("FAIL load_100 got %h want 100", {minutes0, seconds1, seconds0});
    end
    do_start();
    vectors++;
    if ({running, done, expired} !== 3'b100) begin
      miscompares++; $display("FAIL start_running got %b want 100", {running, done, expired});
    end
    cycles(3);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h100) begin
      miscompares++; $display("FAIL pre_first_tick got %h want 100", {minutes0, seconds1, seconds0});
    end
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h059) begin
      miscompares++; $display("FAIL first_tick got %h want 059", {minutes0, seconds1, seconds0});
    end
    cycles(235);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h001, 3'b100}) begin
      miscompares++; $display("FAIL before_zero got %h/%b want 001/100", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h000, 3'b011}) begin
      miscompares++; $display("FAIL at_zero got %h/%b want 000/011", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h000, 3'b001}) begin
      miscompares++; $display("FAIL done_one_cycle got %h/%b want 000/001", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
  endtask

  task automatic test_borrow();
    step = 6'd10;
    do_load(12'h205);
    vectors++;
    if (expired !== 1'b0) begin
      miscompares++; $display("FAIL load_clears_expired got %b want 0", expired);
    end
    do_start();
    cycles(4);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h155) begin
      miscompares++; $display("FAIL borrow_tick1 got %h want 155", {minutes0, seconds1, seconds0});
    end
    cycles(4);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h145, 1'b1}) begin
      miscompares++; $display("FAIL borrow_tick2 got %h/%b want 145/1", {minutes0, seconds1, seconds0}, running);
    end
  endtask

  task automatic test_saturate();
    step = 6'd30;
    do_load(12'h007);
    do_start();
    cycles(4);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h000, 3'b011}) begin
      miscompares++; $display("FAIL saturate got %h/%b want 000/011", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
    cycles(1);
    do_start();
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h000, 3'b001}) begin
      miscompares++; $display("FAIL start_in_done got %h/%b want 000/001", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
  endtask

  task automatic test_pause_resume();
    step = 6'd1;
    do_load(12'h030);
    do_start();
    cycles(2);
    pause = 1'b1;
    cycles(1);
    pause = 1'b0;
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h030, 1'b0}) begin
      miscompares++; $display("FAIL paused got %h/%b want 030/0", {minutes0, seconds1, seconds0}, running);
    end
    cycles(9);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h030, 1'b0}) begin
      miscompares++; $display("FAIL pause_hold got %h/%b want 030/0", {minutes0, seconds1, seconds0}, running);
    end
    do_start();
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h030, 1'b1}) begin
      miscompares++; $display("FAIL resume_early got %h/%b want 030/1", {minutes0, seconds1, seconds0}, running);
    end
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h029) begin
      miscompares++; $display("FAIL resume_tick got %h want 029", {minutes0, seconds1, seconds0});
    end
  endtask

  task automatic test_pause_on_tick();
    step = 6'd1;
    do_load(12'h030);
    do_start();
    cycles(3);
    pause = 1'b1;
    cycles(1);
    pause = 1'b0;
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h030, 1'b0}) begin
      miscompares++; $display("FAIL pause_on_tick got %h/%b want 030/0", {minutes0, seconds1, seconds0}, running);
    end
    do_start();
    cycles(1);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h029) begin
      miscompares++; $display("FAIL held_tick_resume got %h want 029", {minutes0, seconds1, seconds0});
    end
  endtask

  task automatic test_load_on_tick();
    step = 6'd1;
    do_load(12'h001);
    do_start();
    cycles(3);
    do_load(12'h002);
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== {12'h002, 3'b000}) begin
      miscompares++; $display("FAIL load_on_tick got %h/%b want 002/000", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
  endtask

  task automatic test_step_zero();
    step = 6'd0;
    do_load(12'h005);
    do_start();
    cycles(8);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h005, 1'b1}) begin
      miscompares++; $display("FAIL step_zero got %h/%b want 005/1", {minutes0, seconds1, seconds0}, running);
    end
  endtask

  task automatic test_zero_and_clamp();
    do_load(12'h000);
    do_start();
    cycles(1);
    vectors++;
    if ({running, done, expired} !== 3'b000) begin
      miscompares++; $display("FAIL start_at_zero got %b want 000", {running, done, expired});
    end
    do_load({4'd15, 4'd7, 4'd12});
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h959) begin
      miscompares++; $display("FAIL clamp got %h want 959", {minutes0, seconds1, seconds0});
    end
  endtask

  task automatic test_priority_and_async_reset();
    step = 6'd1;
    do_load(12'h030);
    do_start();
    cycles(2);
    start = 1'b1;
    pause = 1'b1;
    cycles(1);
    start = 1'b0;
    pause = 1'b0;
    vectors++;
    if (running !== 1'b0) begin
      miscompares++; $display("FAIL pause_beats_start got %b want 0", running);
    end
    cycles(5);
    vectors++;
    if ({minutes0, seconds1, seconds0} !== 12'h030) begin
      miscompares++; $display("FAIL paused_hold2 got %h want 030", {minutes0, seconds1, seconds0});
    end
    do_start();
    cycles(6);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h028, 1'b1}) begin
      miscompares++; $display("FAIL mid_count got %h/%b want 028/1", {minutes0, seconds1, seconds0}, running);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({minutes0, seconds1, seconds0, running, done, expired} !== 15'h0) begin
      miscompares++; $display("FAIL async_reset got %h/%b want 000/000", {minutes0, seconds1, seconds0}, {running, done, expired});
    end
    cycles(1);
    reset = 1'b0;
    cycles(6);
    vectors++;
    if ({minutes0, seconds1, seconds0, running} !== {12'h000, 1'b0}) begin
      miscompares++; $display("FAIL after_reset got %h/%b want 000/0", {minutes0, seconds1, seconds0}, running);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; step = 6'd1;
    load_m0 = '0; load_s1 = '0; load_s0 = '0;
    #1;
    test_reset();
    test_full_countdown();
    test_borrow();
    test_saturate();
    test_pause_resume();
    test_pause_on_tick();
    test_load_on_tick();
    test_step_zero();
    test_zero_and_clamp();
    test_priority_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Remaining-time countdown for the music player: loads a track duration as BCD digits (m:ss, 0:00–9:59), decrements it once per second while playing, and flags expiry. It is the counting-down counterpart of the elapsed-time timer. Both feed the same display path with identical digit encoding. All logic is synchronous to `clk`, with a single internal prescaler and no derived clocks.

## Interface
- `CLKS_PER_SEC`, default 50_000_000: `clk` cycles per one-second tick. Minimum value is 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `load`  in  1  loads `load_m0`/`load_s1`/`load_s0` into the counter.
- `load_m0`  in  4  minutes digit to load, BCD.
- `load_s1`  in  4  tens-of-seconds digit to load, BCD.
- `load_s0`  in  4  units-of-seconds digit to load, BCD.
- `start`  in  1  run / resume request.
- `pause`  in  1  pause request.
- `step`  in  6  seconds subtracted per tick, 0–63. Sampled at the tick.
- `minutes0`  out  4  remaining minutes, 0–9.
- `seconds1`  out  4  remaining tens of seconds, 0–5.
- `seconds0`  out  4  remaining units of seconds, 0–9.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the count reaches 0:00.
- `expired`  out  1  level, high while in DONE.

## Operation
- The remaining time is T = 60·m0 + 10·s1 + s0, range 0–599. Digits are always valid BCD with s1 ≤ 5.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: holding.
  - DONE: reached zero.
- Input priority: `reset` > `load` > `pause` > `start`.
- `load`, from any state:
  - Go to IDLE and clear the prescaler.
  - Store the digits, with each out-of-range digit clamped: s0 > 9 → 9, s1 > 5 → 5, m0 > 9 → 9.
  - Clear `expired`.
- `start`:
  - In IDLE or PAUSED with T > 0: go to RUN.
  - With T = 0: ignored.
  - In RUN or DONE: ignored.
- `pause`:
  - In RUN: go to PAUSED. The prescaler holds its value, and a resume continues from it.
  - In all other states: ignored.
  - If asserted in the same cycle as `start`, `pause` wins.
- Tick, generated in RUN only:
  - On a tick, T ← max(T − `step`, 0). Digit arithmetic includes full borrow across s0→s1→m0.
  - `step` = 0: no change to T.
  - `step` ≥ T: saturate at 0:00 with no wrap.
- On the tick that makes T = 0:
  - Go to DONE.
  - Pulse `done` for one cycle.
  - Set `expired`.
  - Clear `running`.
- DONE is left only by `load` or `reset`.

## Timing
- Reset values:
  - All digits 0.
  - State IDLE.
  - Prescaler 0.
  - `running`, `done` and `expired` all 0.
- All outputs are registered.
- The prescaler increments each cycle in RUN. The tick fires in the cycle when the prescaler equals `CLKS_PER_SEC`−1, and the prescaler then returns to 0.
- The first decrement is visible `CLKS_PER_SEC` cycles after the cycle in which `start` is sampled.
- The digits update on the clock edge ending the tick cycle. `done` and `expired` rise on that same edge, together with the digits showing 0:00.
- `running` rises the edge after `start` is sampled and falls the edge after `pause` is sampled.
- A `pause` coincident with the tick cycle suppresses that tick: no decrement, and the prescaler holds at `CLKS_PER_SEC`−1.
- A `load` coincident with a tick wins. The loaded value appears with no decrement, and `done` stays low.
- An asynchronous `reset` mid-count returns all outputs to their reset values immediately.

## Test plan
All scenarios use `CLKS_PER_SEC` = 4.
1. Reset, then load 1:00 and start with `step` = 1. After 4 cycles the display shows 0:59. After 240 cycles it shows 0:00, with `done` high for exactly 1 cycle and `expired` held high.
2. Load 2:05 with `step` = 10 and start. The first tick gives 1:55 (borrow across all digits), the next gives 1:45.
3. Load 0:07 with `step` = 30 and start. The first tick saturates at 0:00 and enters DONE. A subsequent `start` leaves all outputs unchanged.
4. Load 0:30 and start. Pause after 2 cycles, hold for 10 cycles, then start again. The first decrement lands exactly 2 cycles after the resume edge, showing 0:29.
5. Load 0:00 and start: `running` stays 0. Load digits s0 = 12, s1 = 7, m0 = 15: the display shows 9:59.
6. In RUN, assert `start` and `pause` together: the block enters PAUSED. Assert `reset` mid-count: the display shows 0:00 with `running`/`done`/`expired` all 0 before the next clock edge.
